out_display_ctrl: RTL and testbench

- Output stage directly downstream of the CPU. Consumes the CPU's registered `out` data word.
- Converts the word to packed BCD with a sequential double-dabble engine (one bit per clock).
- Drives a time-multiplexed, active-low 7-segment display with leading-zero blanking.
- Exposes the stable BCD result for other consumers.

---
 rtl/out_display_ctrl.sv | 179 +++++++++++++++++
 tb/tb_out_display_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/out_display_ctrl.sv
// out_display_ctrl: converts the CPU output word to packed BCD with a
// one-bit-per-clock double-dabble engine and scans the result onto a
// time-multiplexed, active-low 7-segment display with leading-zero blanking.
module out_display_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    busy,
  output logic                    valid,
  output logic [4*DIGITS-1:0]     bcd,
  output logic [6:0]              seg,
  output logic [DIGITS-1:0]       an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] bin_sh_q, bin_sh_d;
  logic [BCD_W-1:0]      work_q, work_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [REF_W-1:0]      refresh_cnt_q, refresh_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic [BCD_W-1:0]      adj;
  logic                  carry_unused;
  logic [DIGITS-1:0]     lz;
  logic [3:0]            digit_val;
  logic                  blank;

  // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion FSM: latch a new word, shift it through the add-3 digits, publish.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    bin_sh_d     = bin_sh_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    bcd_d        = bcd_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    carry_unused = 1'b0;
    adj          = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      IDLE: begin
        if ((in_data != last_q) || !valid_q) begin
          bin_sh_d = in_data;
          last_d   = in_data;
          work_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        {carry_unused, work_d, bin_sh_d} = {adj, bin_sh_q, 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = work_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan: free-running refresh divider, digit select, blanking and decode.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + REF_W'(1);
    digit_idx_d   = digit_idx_q;
    if (refresh_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt_d = '0;
      if (digit_idx_q == IDX_W'(DIGITS - 1)) begin
        digit_idx_d = '0;
      end else begin
        digit_idx_d = digit_idx_q + IDX_W'(1);
      end
    end
    lz[DIGITS-1] = (bcd_q[BCD_W-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    end
    an_d      = '1;
    digit_val = 4'd0;
    blank     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        an_d[i]   = 1'b0;
        digit_val = bcd_q[4*i +: 4];
        blank     = (i != 0) && lz[i];
      end
    end
    seg_d = blank ? 7'b1111111 : seg_decode(digit_val);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= '0;
      bin_sh_q      <= '0;
      work_q        <= '0;
      cnt_q         <= '0;
      bcd_q         <= '0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
      an_q          <= ~DIGITS'(1);
      seg_q         <= 7'b1000000;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      bin_sh_q      <= bin_sh_d;
      work_q        <= work_d;
      cnt_q         <= cnt_d;
      bcd_q         <= bcd_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign bcd   = bcd_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_out_display_ctrl.sv
// Directed bench for out_display_ctrl: conversion timing, BCD results,
// input-change handling, mid-conversion reset and the multiplexed display.
module tb_out_display_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        busy;
  logic        valid;
  logic [19:0] bcd;
  logic [6:0]  seg;
  logic [4:0]  an;

  int vectors;
  int miscompares;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SB = 7'b1111111;

  out_display_ctrl #(
    .DATA_WIDTH (16),
    .DIGITS     (5),
    .REFRESH_DIV(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_data(in_data),
    .busy   (busy),
    .valid  (valid),
    .bcd    (bcd),
    .seg    (seg),
    .an     (an)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new word while idle and check the 17-edge conversion timing.
  task automatic applyStimulus(input string tag, input logic [15:0] value,
                               input logic [19:0] prev_bcd, input logic [19:0] exp_bcd);
    @(negedge clk);
    in_data = value;
    stepEdges(1);
    checkOutput({tag, " busy_start"}, 32'(busy), 32'd1);
    stepEdges(16);
    checkOutput({tag, " busy_k16"}, 32'(busy), 32'd1);
    checkOutput({tag, " bcd_hold"}, 32'(bcd), 32'(prev_bcd));
    stepEdges(1);
    checkOutput({tag, " busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, " valid"}, 32'(valid), 32'd1);
    checkOutput({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
  endtask

  // Watch 20 cycles of scanning: one-hot-zero an, matching seg, step order, 4-cycle holds.
  task automatic scanDisplay(input string tag, input logic [34:0] segs);
    int run_len[5];
    int prev_pos;
    int pos;
    prev_pos = -1;
    for (int i = 0; i < 5; i++) run_len[i] = 0;
    for (int c = 0; c < 20; c++) begin
      pos = -1;
      for (int i = 0; i < 5; i++) if (an[i] == 1'b0) pos = i;
      checkOutput({tag, " an_onehot"}, 32'($countones(~an)), 32'd1);
      if (pos >= 0) begin
        checkOutput({tag, " seg"}, 32'(seg), 32'(segs[7*pos +: 7]));
        if (prev_pos >= 0 && pos != prev_pos)
          checkOutput({tag, " an_step"}, 32'(pos), 32'((prev_pos + 1) % 5));
        run_len[pos]++;
        prev_pos = pos;
      end
      stepEdges(1);
    end
    for (int i = 0; i < 5; i++)
      checkOutput({tag, " an_hold"}, 32'(run_len[i]), 32'd4);
  endtask

  // Directed test sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    in_data     = 16'd0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    #1;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst valid", 32'(valid), 32'd0);
    checkOutput("rst bcd", 32'(bcd), 32'd0);
    checkOutput("rst an", 32'(an), 32'b11110);
    checkOutput("rst seg", 32'(seg), 32'(S0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    stepEdges(1);
    checkOutput("zero busy_e1", 32'(busy), 32'd1);
    checkOutput("zero valid_e1", 32'(valid), 32'd0);
    stepEdges(16);
    checkOutput("zero busy_e17", 32'(busy), 32'd1);
    stepEdges(1);
    checkOutput("zero busy_e18", 32'(busy), 32'd0);
    checkOutput("zero valid_e18", 32'(valid), 32'd1);
    checkOutput("zero bcd", 32'(bcd), 32'h00000);
    stepEdges(1);
    scanDisplay("zero", {SB, SB, SB, SB, S0});

    applyStimulus("12345", 16'd12345, 20'h00000, 20'h12345);
    stepEdges(1);
    scanDisplay("12345", {S1, S2, S3, S4, S5});

    applyStimulus("65535", 16'd65535, 20'h12345, 20'h65535);
    applyStimulus("10000", 16'd10000, 20'h65535, 20'h10000);
    stepEdges(1);
    scanDisplay("10000", {S1, S0, S0, S0, S0});

    // 100, replaced by 200 two cycles in; 150 glitches during the second run.
    @(negedge clk);
    in_data = 16'd100;
    stepEdges(1);
    checkOutput("100 busy_start", 32'(busy), 32'd1);
    stepEdges(2);
    in_data = 16'd200;
    stepEdges(15);
    checkOutput("100 bcd", 32'(bcd), 32'h00100);
    checkOutput("100 busy_end", 32'(busy), 32'd0);
    stepEdges(1);
    checkOutput("200 busy_start", 32'(busy), 32'd1);
    in_data = 16'd150;
    stepEdges(3);
    in_data = 16'd200;
    stepEdges(13);
    checkOutput("200 bcd_hold", 32'(bcd), 32'h00100);
    stepEdges(1);
    checkOutput("200 bcd", 32'(bcd), 32'h00200);
    checkOutput("200 busy_end", 32'(busy), 32'd0);
    stepEdges(3);
    checkOutput("150 no_restart", 32'(busy), 32'd0);
    checkOutput("150 bcd_kept", 32'(bcd), 32'h00200);

    applyStimulus("7", 16'd7, 20'h00200, 20'h00007);
    stepEdges(1);
    scanDisplay("7", {SB, SB, SB, SB, S7});

    // Reset in the middle of converting 999.
    applyStimulus("42", 16'd42, 20'h00007, 20'h00042);
    @(negedge clk);
    in_data = 16'd999;
    stepEdges(1);
    checkOutput("999 busy_start", 32'(busy), 32'd1);
    stepEdges(8);
    rst_n = 1'b0;
    #1;
    checkOutput("abort bcd", 32'(bcd), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort valid", 32'(valid), 32'd0);
    checkOutput("abort an", 32'(an), 32'b11110);
    checkOutput("abort seg", 32'(seg), 32'(S0));
    @(negedge clk);
    rst_n = 1'b1;
    stepEdges(17);
    checkOutput("999 busy_e17", 32'(busy), 32'd1);
    checkOutput("999 bcd_e17", 32'(bcd), 32'd0);
    stepEdges(1);
    checkOutput("999 bcd", 32'(bcd), 32'h00999);
    checkOutput("999 valid", 32'(valid), 32'd1);
    checkOutput("999 busy_end", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
